// File: rtl/playlist_sequencer_if.sv
// Button/switch inputs and player-control outputs of the playlist sequencer.
// The slave modport is the sequencer's view; master is the board/bench side.
interface playlist_sequencer_if #(
  parameter int unsigned SONG_W = 4
);
  logic              next_btn;
  logic              prev_btn;
  logic              play_btn;
  logic              loop_en;
  logic              song_done;
  logic [SONG_W-1:0] song_number;
  logic              player_en;
  logic              player_restart;
  logic [1:0]        state_out;

  modport master (
    output next_btn, prev_btn, play_btn, loop_en, song_done,
    input  song_number, player_en, player_restart, state_out
  );

  modport slave (
    input  next_btn, prev_btn, play_btn, loop_en, song_done,
    output song_number, player_en, player_restart, state_out
  );
endinterface

// File: rtl/playlist_sequencer.sv
// Song selection and play/pause/auto-advance control for the song player,
// with an inter-song silent gap and synchronized, edge-detected buttons.
module playlist_sequencer #(
  parameter int unsigned TOTAL_SONGS = 3,
  parameter int unsigned SONG_W      = 4,
  parameter int unsigned GAP_CYCLES  = 50_000_000
) (
  input logic                  clk,
  input logic                  reset,
  playlist_sequencer_if.slave  bus
);
  localparam int unsigned CNT_W = $clog2(GAP_CYCLES + 1);
  localparam logic [SONG_W-1:0] LastSong = SONG_W'(TOTAL_SONGS - 1);
  localparam logic [CNT_W-1:0]  GapLoad  = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StPlay  = 2'd1,
    StPause = 2'd2,
    StGap   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [SONG_W-1:0] song_q, song_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              restart_q, restart_d;
  logic              en_q;

  // Per button: [0] first sync stage, [1] second stage, [2] delayed copy for edge detect.
  logic [2:0] next_sync_q, prev_sync_q, play_sync_q;

  logic              next_ev, prev_ev, play_ev;
  logic              sc;
  logic [SONG_W-1:0] sc_song;

  assign next_ev = next_sync_q[1] & ~next_sync_q[2];
  assign prev_ev = prev_sync_q[1] & ~prev_sync_q[2];
  assign play_ev = play_sync_q[1] & ~play_sync_q[2];

  // A song change exists only if it actually moves the index.
  always_comb begin
    sc      = 1'b0;
    sc_song = song_q;
    if (next_ev && !prev_ev) begin
      if (song_q == LastSong) begin
        if (bus.loop_en) begin
          sc      = 1'b1;
          sc_song = '0;
        end
      end else begin
        sc      = 1'b1;
        sc_song = song_q + SONG_W'(1);
      end
    end else if (prev_ev && !next_ev) begin
      if (song_q == '0) begin
        if (bus.loop_en) begin
          sc      = 1'b1;
          sc_song = LastSong;
        end
      end else begin
        sc      = 1'b1;
        sc_song = song_q - SONG_W'(1);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    song_d    = song_q;
    cnt_d     = cnt_q;
    restart_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (sc) begin
          song_d = sc_song;
        end else if (play_ev) begin
          state_d   = StPlay;
          restart_d = 1'b1;
        end
      end
      StPlay: begin
        if (sc) begin
          song_d    = sc_song;
          restart_d = 1'b1;
        end else if (play_ev) begin
          state_d = StPause;
        end else if (bus.song_done) begin
          if (song_q == LastSong && !bus.loop_en) begin
            state_d = StIdle;
          end else begin
            song_d  = (song_q == LastSong) ? '0 : song_q + SONG_W'(1);
            cnt_d   = GapLoad;
            state_d = StGap;
          end
        end
      end
      StPause: begin
        if (sc) begin
          song_d    = sc_song;
          restart_d = 1'b1;
        end else if (play_ev) begin
          state_d = StPlay;
        end
      end
      StGap: begin
        if (sc) begin
          song_d    = sc_song;
          state_d   = StPlay;
          restart_d = 1'b1;
        end else if (play_ev) begin
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          state_d   = StPlay;
          restart_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      song_q      <= '0;
      cnt_q       <= '0;
      restart_q   <= 1'b0;
      en_q        <= 1'b0;
      next_sync_q <= '0;
      prev_sync_q <= '0;
      play_sync_q <= '0;
    end else begin
      state_q     <= state_d;
      song_q      <= song_d;
      cnt_q       <= cnt_d;
      restart_q   <= restart_d;
      en_q        <= (state_d == StPlay);
      next_sync_q <= {next_sync_q[1:0], bus.next_btn};
      prev_sync_q <= {prev_sync_q[1:0], bus.prev_btn};
      play_sync_q <= {play_sync_q[1:0], bus.play_btn};
    end
  end

  assign bus.song_number    = song_q;
  assign bus.player_en      = en_q;
  assign bus.player_restart = restart_q;
  assign bus.state_out      = state_q;
endmodule

// File: tb/tb_playlist_sequencer.sv
// Directed checks of playlist_sequencer with TOTAL_SONGS=3, GAP_CYCLES=4.
module tb_playlist_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  playlist_sequencer_if #(.SONG_W(4)) bus ();

  playlist_sequencer #(
    .TOTAL_SONGS(3),
    .SONG_W     (4),
    .GAP_CYCLES (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] IDLE = 2'd0, PLAY = 2'd1, PAUSE = 2'd2, GAP = 2'd3;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] st, input int song,
                         input logic en, input logic rst);
    chk({tag, ".state"}, 32'(bus.state_out), 32'(st));
    chk({tag, ".song"}, 32'(bus.song_number), 32'(song));
    chk({tag, ".en"}, 32'(bus.player_en), 32'(en));
    chk({tag, ".restart"}, 32'(bus.player_restart), 32'(rst));
  endtask

  // mask bit0=next, bit1=prev, bit2=play; returns just after the acting edge
  task automatic press(input logic [2:0] mask);
    bus.next_btn = mask[0];
    bus.prev_btn = mask[1];
    bus.play_btn = mask[2];
    tick();
    bus.next_btn = 1'b0;
    bus.prev_btn = 1'b0;
    bus.play_btn = 1'b0;
    tick();
    tick();
  endtask

  task automatic done_pulse();
    bus.song_done = 1'b1;
    tick();
    bus.song_done = 1'b0;
  endtask

  initial begin
    bus.next_btn  = 1'b0;
    bus.prev_btn  = 1'b0;
    bus.play_btn  = 1'b0;
    bus.loop_en   = 1'b0;
    bus.song_done = 1'b0;
    tick();
    tick();
    chk_all("reset", IDLE, 0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    chk_all("idle", IDLE, 0, 1'b0, 1'b0);

    // 1. play from IDLE
    press(3'b100);
    chk_all("play1", PLAY, 0, 1'b1, 1'b1);
    tick();
    chk_all("play1_after", PLAY, 0, 1'b1, 1'b0);

    // 2. song_done -> 4-cycle gap then PLAY with restart
    done_pulse();
    chk_all("gap_c1", GAP, 1, 1'b0, 1'b0);
    tick();
    chk_all("gap_c2", GAP, 1, 1'b0, 1'b0);
    tick();
    chk_all("gap_c3", GAP, 1, 1'b0, 1'b0);
    tick();
    chk_all("gap_c4", GAP, 1, 1'b0, 1'b0);
    tick();
    chk_all("gap_end", PLAY, 1, 1'b1, 1'b1);
    tick();
    chk_all("gap_end_after", PLAY, 1, 1'b1, 1'b0);

    // 3. next in PLAY, then end of last song without and with loop
    press(3'b001);
    chk_all("play_next", PLAY, 2, 1'b1, 1'b1);
    tick();
    done_pulse();
    chk_all("last_noloop", IDLE, 2, 1'b0, 1'b0);
    bus.loop_en = 1'b1;
    press(3'b100);
    chk_all("replay2", PLAY, 2, 1'b1, 1'b1);
    tick();
    done_pulse();
    chk_all("last_loop", GAP, 0, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    tick();
    chk_all("loop_gap_end", PLAY, 0, 1'b1, 1'b1);

    // 5. pause, change song while paused, resume
    press(3'b100);
    chk_all("pause", PAUSE, 0, 1'b0, 1'b0);
    press(3'b001);
    chk_all("pause_next", PAUSE, 1, 1'b0, 1'b1);
    tick();
    chk_all("pause_next_after", PAUSE, 1, 1'b0, 1'b0);
    press(3'b100);
    chk_all("resume", PLAY, 1, 1'b1, 1'b0);

    // 6b. song_done together with play event -> PAUSE, index kept
    bus.play_btn = 1'b1;
    tick();
    bus.play_btn = 1'b0;
    tick();
    done_pulse();
    chk_all("done_vs_play", PAUSE, 1, 1'b0, 1'b0);

    // 4. get to IDLE on song 0, then saturate/wrap/simultaneous
    press(3'b100);
    bus.loop_en = 1'b0;
    press(3'b001);
    chk_all("to_last", PLAY, 2, 1'b1, 1'b1);
    tick();
    done_pulse();
    chk_all("idle2", IDLE, 2, 1'b0, 1'b0);
    press(3'b010);
    press(3'b010);
    chk_all("idle_prev2", IDLE, 0, 1'b0, 1'b0);
    press(3'b010);
    chk_all("prev_sat", IDLE, 0, 1'b0, 1'b0);
    bus.loop_en = 1'b1;
    press(3'b010);
    chk_all("prev_wrap", IDLE, 2, 1'b0, 1'b0);
    press(3'b011);
    chk_all("next_and_prev", IDLE, 2, 1'b0, 1'b0);
    press(3'b001);
    chk_all("next_wrap", IDLE, 0, 1'b0, 1'b0);

    // 6. reset in GAP at count 2
    press(3'b100);
    tick();
    done_pulse();
    tick();
    chk_all("gap_before_reset", GAP, 1, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    chk_all("async_reset", IDLE, 0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;

    // GAP cancelled by play event -> IDLE, index kept
    press(3'b100);
    tick();
    done_pulse();
    press(3'b100);
    chk_all("gap_cancel", IDLE, 1, 1'b0, 1'b0);

    // GAP aborted by song change -> PLAY + restart
    press(3'b100);
    tick();
    done_pulse();
    press(3'b001);
    chk_all("gap_abort", PLAY, 0, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
